uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/rr_priority_select.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and a width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } arb_state_t;

  // Bits needed to index 'value' items; never less than 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UartTx signals of the arbiter, viewed from the arbiter (slave) or its environment (master).
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NrOfRequesters = 4,
  parameter int NrOfDataBits   = 8
);
  localparam int IdWidth = clog2(NrOfRequesters);

  // req[i] is a level that the requester holds, with its byte stable, until the
  // one-cycle ack[i]; uartStart is a one-cycle pulse and uartDone falls at frame
  // start and rises after the stop bit.
  logic [NrOfRequesters-1:0]              req;
  logic [NrOfRequesters*NrOfDataBits-1:0] reqData;
  logic [NrOfRequesters-1:0]              ack;
  logic                                   busy;
  logic [IdWidth-1:0]                     grantId;
  logic                                   uartStart;
  logic [NrOfDataBits-1:0]                uartData;
  logic                                   uartDone;
  logic                                   error;

  modport master (
    output req, reqData, uartDone,
    input  ack, busy, grantId, uartStart, uartData, error
  );

  modport slave (
    input  req, reqData, uartDone,
    output ack, busy, grantId, uartStart, uartData, error
  );

endinterface

// File: rtl/rr_priority_select.sv
// Round-robin picker: first set req bit after 'last', wrapping modulo the channel count.
module rr_priority_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NrOfRequesters = 4,
  localparam int IdWidth        = clog2(NrOfRequesters)
) (
  input  logic [NrOfRequesters-1:0] req,
  input  logic [IdWidth-1:0]        last,
  output logic                      valid,
  output logic [IdWidth-1:0]        index
);

  // Walk from farthest to nearest so the nearest set bit after 'last' is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int off = NrOfRequesters; off >= 1; off--) begin
      if (req[(int'(last) + off) % NrOfRequesters]) begin
        valid = 1'b1;
        index = IdWidth'((int'(last) + off) % NrOfRequesters);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UartTx between several byte producers: round-robin grant, byte latch,
// start pulse and done tracking with a start timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NrOfRequesters = 4,
  parameter  int NrOfDataBits   = 8,
  parameter  int StartTimeout   = 16,
  localparam int IdWidth        = clog2(NrOfRequesters),
  localparam int TimerWidth     = clog2(StartTimeout + 1)
) (
  input  logic       clock,
  input  logic       reset,
  uart_tx_arbiter_if.slave bus,
  output arb_state_t state
);

  logic [NrOfRequesters-1:0] ack_q;
  logic                      busy_q;
  logic [IdWidth-1:0]        grant_q;
  logic [IdWidth-1:0]        last_grant;
  logic                      start_q;
  logic [NrOfDataBits-1:0]   data_q;
  logic                      error_q;
  logic [TimerWidth-1:0]     timer;

  logic                      sel_valid;
  logic [IdWidth-1:0]        sel_index;
  logic [NrOfDataBits-1:0]   sel_byte;

  rr_priority_select #(.NrOfRequesters(NrOfRequesters)) u_select (
    .req   (bus.req),
    .last  (last_grant),
    .valid (sel_valid),
    .index (sel_index)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NrOfRequesters; i++) begin
      if (sel_index == IdWidth'(i)) sel_byte = bus.reqData[i*NrOfDataBits +: NrOfDataBits];
    end
  end

  // done is never looked at in IDLE or START, so an unknown done after reset is harmless.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      last_grant <= IdWidth'(NrOfRequesters - 1);
      start_q    <= 1'b0;
      data_q     <= '0;
      error_q    <= 1'b0;
      timer      <= '0;
    end else begin
      ack_q   <= '0;
      start_q <= 1'b0;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            data_q     <= sel_byte;
            grant_q    <= sel_index;
            last_grant <= sel_index;
            ack_q      <= NrOfRequesters'(1) << sel_index;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!bus.uartDone) begin
            state <= WAIT_HIGH;
          end else if (timer == TimerWidth'(StartTimeout - 1)) begin
            // Transmitter never started: drop the byte rather than retry.
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (bus.uartDone) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.grantId   = grant_q;
  assign bus.uartStart = start_q;
  assign bus.uartData  = data_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed tables/sequences plus random traffic
// against a transaction-level round-robin model with a scripted UartTx.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_t dbg_state;

  uart_tx_arbiter_if #(.NrOfRequesters(N), .NrOfDataBits(DB)) bus ();

  uart_tx_arbiter #(.NrOfRequesters(N), .NrOfDataBits(DB), .StartTimeout(TO)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // UartTx model configuration: done falls cfg_a cycles after start, stays low cfg_b cycles.
  int cfg_a     = 1;
  int cfg_b     = 3;
  bit cfg_stall = 1'b0;
  bit stall_now = 1'b0;
  int low_at    = -1;
  int high_at   = -1;

  typedef struct {
    int             prev;
    logic [N-1:0]   req;
    int             exp;
  } rr_vec_t;
  rr_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic uart_reset();
    stall_now    = 1'b0;
    low_at       = -1;
    high_at      = -1;
    bus.uartDone = 1'b1;
  endtask

  // One cycle: step to the sampling edge, then let the UartTx model react.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.uartStart === 1'b1) begin
      stall_now = cfg_stall;
      low_at    = cyc + cfg_a;
      high_at   = low_at + cfg_b;
    end
    bus.uartDone = (!stall_now && cyc >= low_at && cyc < high_at) ? 1'b0 : 1'b1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    tick();
    tick();
    uart_reset();
    rst = 1'b0;
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grantId, 0);
    check("rst_start", bus.uartStart, 0);
    check("rst_data", bus.uartData, 0);
    check("rst_error", bus.error, 0);
    check("rst_state", dbg_state, IDLE);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check(name, bus.busy, 0);
  endtask

  task automatic serve(input int ch, input logic [DB-1:0] data);
    bus.req                  = '0;
    bus.req[ch]              = 1'b1;
    bus.reqData[ch*DB +: DB] = data;
    tick();
    check("serve_ack", bus.ack, 1 << ch);
    check("serve_data", bus.uartData, data);
    bus.req = '0;
    wait_idle("serve_idle");
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic test_single();
    int starts, bad_data, n;
    starts = 0; bad_data = 0; n = 0;
    do_reset();
    cfg_a = 2; cfg_b = 100; cfg_stall = 1'b0;
    bus.reqData[7:0] = 8'h41;
    bus.req          = 4'b0001;
    tick();
    check("single_ack", bus.ack, 4'b0001);
    check("single_start", bus.uartStart, 1);
    check("single_data", bus.uartData, 8'h41);
    check("single_busy", bus.busy, 1);
    bus.req = '0;
    while (bus.busy === 1'b1 && n < 300) begin
      tick();
      n++;
      if (bus.uartStart === 1'b1) starts++;
      if (bus.uartData !== 8'h41) bad_data++;
    end
    check("single_extra_start", starts, 0);
    check("single_data_stable", bad_data, 0);
    check("single_busy_fall", cyc, high_at + 1);
    check("single_idle", bus.busy, 0);
  endtask

  task automatic test_table();
    cfg_a = 1; cfg_b = 3; cfg_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      serve(vecs[i].prev, 8'h20);
      for (int c = 0; c < N; c++) bus.reqData[c*DB +: DB] = 8'(8'h40 + c + 4*i);
      bus.req = vecs[i].req;
      tick();
      check("tbl_ack", bus.ack, 1 << vecs[i].exp);
      check("tbl_grant", bus.grantId, vecs[i].exp);
      check("tbl_data", bus.uartData, 8'(8'h40 + vecs[i].exp + 4*i));
      bus.req = '0;
      wait_idle("tbl_idle");
    end
  endtask

  task automatic test_contention();
    int order[5];
    int n;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    cfg_a = 1; cfg_b = 3; cfg_stall = 1'b0;
    for (int c = 0; c < N; c++) bus.reqData[c*DB +: DB] = 8'(8'h10 + c);
    bus.req = '1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      tick();
      while (bus.ack === '0 && n < 100) begin
        tick();
        n++;
      end
      check("cont_ack", bus.ack, 1 << order[g]);
      check("cont_grant", bus.grantId, order[g]);
      check("cont_data", bus.uartData, 8'(8'h10 + order[g]));
    end
    bus.req = '0;
    wait_idle("cont_idle");
  endtask

  task automatic test_timeout();
    int s, errs, err_cyc;
    errs = 0; err_cyc = -1;
    do_reset();
    cfg_a = 1; cfg_b = 3; cfg_stall = 1'b1;
    bus.reqData[7:0] = 8'h55;
    bus.req          = 4'b0001;
    tick();
    s = cyc;
    check("to_ack", bus.ack, 4'b0001);
    bus.req = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.error === 1'b1) begin
        errs++;
        err_cyc = cyc;
      end
    end
    check("to_err_count", errs, 1);
    check("to_err_time", err_cyc, s + TO + 1);
    check("to_busy", bus.busy, 0);
    check("to_state", dbg_state, IDLE);
    cfg_stall = 1'b0;
    serve(1, 8'h66);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_a = 1; cfg_b = 50; cfg_stall = 1'b0;
    bus.reqData[23:16] = 8'h77;
    bus.req            = 4'b0100;
    tick();
    check("mid_ack", bus.ack, 4'b0100);
    bus.req = '0;
    repeat (10) tick();
    check("mid_state", dbg_state, WAIT_HIGH);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    uart_reset();
    check("mid_busy", bus.busy, 0);
    check("mid_ack0", bus.ack, 0);
    check("mid_start", bus.uartStart, 0);
    check("mid_grant", bus.grantId, 0);
    check("mid_idle_state", dbg_state, IDLE);
    bus.req = '1;
    tick();
    check("mid_first_grant", bus.ack, 4'b0001);
    bus.req = '0;
    wait_idle("mid_idle");
  endtask

  task automatic test_late_and_withdrawn();
    int n, early, acks;
    n = 0; early = 0; acks = 0;
    do_reset();
    cfg_a = 1; cfg_b = 20; cfg_stall = 1'b0;
    bus.req = 4'b0001;
    tick();
    check("late_first_ack", bus.ack, 4'b0001);
    bus.req = '0;
    repeat (5) tick();
    check("late_state", dbg_state, WAIT_HIGH);
    bus.reqData[23:16] = 8'h2c;
    bus.req            = 4'b0100;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus.ack !== '0) early++;
    end
    check("late_no_early_ack", early, 0);
    tick();
    check("late_ack", bus.ack, 4'b0100);
    check("late_data", bus.uartData, 8'h2c);
    bus.req = '0;
    wait_idle("late_idle");

    bus.req = 4'b0001;
    tick();
    check("wd_first_ack", bus.ack, 4'b0001);
    bus.req = '0;
    repeat (3) tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus.ack !== '0) acks++;
    end
    repeat (5) begin
      tick();
      if (bus.ack !== '0) acks++;
    end
    check("wd_no_ack", acks, 0);
  endtask

  task automatic test_random();
    logic [N-1:0]    req_prev;
    logic [N*DB-1:0] data_prev;
    int model_last, free_from, frame_s, busy_end, err_at, ch;
    do_reset();
    model_last = N - 1;
    free_from  = cyc;
    frame_s    = -1;
    busy_end   = -1;
    err_at     = -1;
    req_prev   = '0;
    data_prev  = bus.reqData;
    cfg_stall  = ($urandom_range(0, 5) == 0);
    cfg_a      = $urandom_range(0, 3);
    cfg_b      = $urandom_range(2, 12);
    for (int k = 0; k < 3000; k++) begin
      tick();
      ch = -1;
      if (cyc - 1 >= free_from && req_prev != '0) begin
        ch = rr_pick(req_prev, model_last);
        check("rnd_ack", bus.ack, 1 << ch);
        check("rnd_start", bus.uartStart, 1);
        check("rnd_grant", bus.grantId, ch);
        check("rnd_data", bus.uartData, data_prev[ch*DB +: DB]);
        check("rnd_busy_grant", bus.busy, 1);
        check("rnd_err_grant", bus.error, 0);
        model_last = ch;
        frame_s    = cyc;
        if (cfg_stall) begin
          busy_end = cyc + TO;
          err_at   = cyc + TO + 1;
        end else begin
          busy_end = cyc + cfg_a + cfg_b;
          err_at   = -1;
        end
        free_from = busy_end + 1;
        cfg_stall = ($urandom_range(0, 5) == 0);
        cfg_a     = $urandom_range(0, 3);
        cfg_b     = $urandom_range(2, 12);
      end else begin
        check("rnd_no_ack", bus.ack, 0);
        check("rnd_no_start", bus.uartStart, 0);
        check("rnd_busy", bus.busy, (cyc >= frame_s && cyc <= busy_end));
        check("rnd_error", bus.error, (cyc == err_at));
      end
      for (int c = 0; c < N; c++) begin
        if (c == ch) bus.req[c] = ($urandom_range(0, 1) == 1);
        else if (bus.req[c]) begin
          if ($urandom_range(0, 39) == 0) bus.req[c] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) bus.req[c] = 1'b1;
        if ($urandom_range(0, 7) == 0) bus.reqData[c*DB +: DB] = 8'($urandom);
      end
      req_prev  = bus.req;
      data_prev = bus.reqData;
    end
    bus.req = '0;
    wait_idle("rnd_idle");
  endtask

  initial begin
    vecs[0] = '{3, 4'b1111, 0};
    vecs[1] = '{0, 4'b1111, 1};
    vecs[2] = '{1, 4'b1001, 3};
    vecs[3] = '{2, 4'b0001, 0};
    vecs[4] = '{3, 4'b0100, 2};
    vecs[5] = '{1, 4'b0010, 1};
    vecs[6] = '{2, 4'b1011, 3};
    vecs[7] = '{0, 4'b0001, 0};
    bus.req      = '0;
    bus.reqData  = '0;
    bus.uartDone = 1'b1;

    test_single();
    test_table();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_late_and_withdrawn();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
